// File: rtl/async_tx_queue.sv
// Transmit queue for the source side of the toggle-based async handshake: FIFO plus a
// send/wait FSM that issues one word at a time. Optional ack watchdog: ASYNC_TX_TIMEOUT_EN.
module async_tx_queue #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [DATA_W-1:0]        hs_data,
    output logic                     hs_valid,
    input  logic                     hs_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     busy,
    input  logic                     err_clr,
    output logic                     timeout_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [LW-1:0]       level_q;
    logic                push, pop, load_head;

    // Full is taken from the registered level, so a same-cycle pop cannot admit a push.
    assign in_ready = (level_q != LW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign level    = level_q;
    assign hs_valid = (state == S_SEND);
    assign busy     = (state != S_IDLE);

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        load_head = 1'b0;
        case (state)
            S_IDLE: begin
                if (level_q != '0) begin
                    state_nxt = S_SEND;
                    load_head = 1'b1;
                end
            end
            S_SEND: state_nxt = S_WAIT;
            S_WAIT: begin
                // Head stays queued until acked; hs_ready outside WAIT is ignored.
                if (hs_ready) begin
                    pop       = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            hs_data <= '0;
        end else begin
            state <= state_nxt;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
            if (load_head) hs_data <= mem[rd_ptr];
        end
    end

    // Storage needs no reset; pointers and level define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

`ifdef ASYNC_TX_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] wd_cnt;
    logic          wd_hit;
    logic          err_q;

    assign wd_hit      = (state == S_WAIT) && !hs_ready && (wd_cnt == CW'(TIMEOUT - 1));
    assign timeout_err = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state == S_SEND)
                wd_cnt <= '0;
            else if (state == S_WAIT && !hs_ready && !wd_hit)
                wd_cnt <= wd_cnt + 1'b1;
            // A timeout in the same cycle as err_clr keeps the flag set.
            if (wd_hit)
                err_q <= 1'b1;
            else if (err_clr)
                err_q <= 1'b0;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg  = ^{err_clr, 32'(TIMEOUT)};
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_async_tx_queue.sv
// Directed table-driven bench for async_tx_queue plus hand-written watchdog sequences.
module tb_async_tx_queue;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] hs_data;
    logic       hs_valid;
    logic       hs_ready;
    logic [2:0] level;
    logic       busy;
    logic       err_clr;
    logic       timeout_err;

    int total = 0;
    int bad   = 0;

`ifdef ASYNC_TX_TIMEOUT_EN
    localparam logic TO_EN = 1'b1;
`else
    localparam logic TO_EN = 1'b0;
`endif

    async_tx_queue #(.DATA_W(8), .DEPTH(4), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .hs_data(hs_data), .hs_valid(hs_valid), .hs_ready(hs_ready), .level(level),
        .busy(busy), .err_clr(err_clr), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       iv;
        logic [7:0] d;
        logic       hr;
        logic       ir;
        logic       hv;
        logic [7:0] hd;
        logic [2:0] lv;
        logic       bz;
    } vec_t;

    vec_t vq[$];

    task automatic v(input logic r, input logic iv, input logic [7:0] d, input logic hr,
                     input logic ir, input logic hv, input logic [7:0] hd,
                     input logic [2:0] lv, input logic bz);
        vq.push_back('{rst: r, iv: iv, d: d, hr: hr, ir: ir, hv: hv, hd: hd, lv: lv, bz: bz});
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Drive inputs, take one rising edge, sample 1ns later.
    task automatic step(input logic r, input logic iv, input logic [7:0] d,
                        input logic hr, input logic clr);
        rst = r; in_valid = iv; in_data = d; hs_ready = hr; err_clr = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached, bad=%0d", bad);
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; hs_ready = 1'b0; err_clr = 1'b0;
        step(1, 0, 8'h00, 0, 0);
        step(1, 0, 8'h00, 0, 0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_hs_valid", 32'(hs_valid), 32'd0);
        chk("rst_hs_data", 32'(hs_data), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(timeout_err), 32'd0);

        //  rst iv data  hr | ir hv hd    lv bz
        // single word: pulse in cycle 2, held until ack
        v(0, 1, 8'hA5, 0,  1, 0, 8'h00, 1, 0);
        v(0, 0, 8'h00, 0,  1, 1, 8'hA5, 1, 1);
        v(0, 0, 8'h00, 0,  1, 0, 8'hA5, 1, 1);
        v(0, 0, 8'h00, 0,  1, 0, 8'hA5, 1, 1);
        v(0, 0, 8'h00, 1,  1, 0, 8'hA5, 0, 0);
        v(0, 0, 8'h00, 0,  1, 0, 8'hA5, 0, 0);
        // fill to full, 5th push refused, ordered drain; acks in IDLE/SEND ignored
        v(0, 1, 8'h01, 0,  1, 0, 8'hA5, 1, 0);
        v(0, 1, 8'h02, 0,  1, 1, 8'h01, 2, 1);
        v(0, 1, 8'h03, 0,  1, 0, 8'h01, 3, 1);
        v(0, 1, 8'h04, 0,  0, 0, 8'h01, 4, 1);
        v(0, 1, 8'h05, 0,  0, 0, 8'h01, 4, 1);
        v(0, 0, 8'h00, 1,  1, 0, 8'h01, 3, 0);
        v(0, 0, 8'h00, 1,  1, 1, 8'h02, 3, 1);
        v(0, 0, 8'h00, 1,  1, 0, 8'h02, 3, 1);
        v(0, 0, 8'h00, 0,  1, 0, 8'h02, 3, 1);
        v(0, 0, 8'h00, 1,  1, 0, 8'h02, 2, 0);
        v(0, 0, 8'h00, 0,  1, 1, 8'h03, 2, 1);
        v(0, 0, 8'h00, 0,  1, 0, 8'h03, 2, 1);
        v(0, 0, 8'h00, 1,  1, 0, 8'h03, 1, 0);
        v(0, 0, 8'h00, 0,  1, 1, 8'h04, 1, 1);
        v(0, 0, 8'h00, 0,  1, 0, 8'h04, 1, 1);
        v(0, 0, 8'h00, 1,  1, 0, 8'h04, 0, 0);
        v(0, 0, 8'h00, 0,  1, 0, 8'h04, 0, 0);
        // full + push + ack in same cycle: pop wins, push refused
        v(0, 1, 8'h11, 0,  1, 0, 8'h04, 1, 0);
        v(0, 1, 8'h12, 0,  1, 1, 8'h11, 2, 1);
        v(0, 1, 8'h13, 0,  1, 0, 8'h11, 3, 1);
        v(0, 1, 8'h14, 0,  0, 0, 8'h11, 4, 1);
        v(0, 1, 8'h15, 1,  1, 0, 8'h11, 3, 0);
        v(0, 0, 8'h00, 0,  1, 1, 8'h12, 3, 1);
        v(0, 0, 8'h00, 0,  1, 0, 8'h12, 3, 1);
        // reset in WAIT with 3 words queued, then a fresh word comes out first
        v(1, 0, 8'h00, 0,  1, 0, 8'h00, 0, 0);
        v(0, 0, 8'h00, 0,  1, 0, 8'h00, 0, 0);
        v(0, 1, 8'h77, 0,  1, 0, 8'h00, 1, 0);
        v(0, 0, 8'h00, 0,  1, 1, 8'h77, 1, 1);
        v(0, 0, 8'h00, 1,  1, 0, 8'h77, 1, 1);
        v(0, 0, 8'h00, 1,  1, 0, 8'h77, 0, 0);

        foreach (vq[i]) begin
            step(vq[i].rst, vq[i].iv, vq[i].d, vq[i].hr, 1'b0);
            chk($sformatf("vec%0d", i),
                32'({in_ready, hs_valid, hs_data, level, busy, timeout_err}),
                32'({vq[i].ir, vq[i].hv, vq[i].hd, vq[i].lv, vq[i].bz, 1'b0}));
        end

        // Watchdog: withhold ack; flag rises only after the 16th WAIT cycle.
        step(0, 1, 8'h3C, 0, 0);
        step(0, 0, 8'h00, 0, 0);
        chk("to_send", 32'({hs_valid, hs_data}), 32'({1'b1, 8'h3C}));
        step(0, 0, 8'h00, 0, 0);
        for (int k = 0; k < 15; k++) step(0, 0, 8'h00, 0, 0);
        chk("to_before", 32'({timeout_err, busy, hs_valid, hs_data}), 32'({1'b0, 1'b1, 1'b0, 8'h3C}));
        step(0, 0, 8'h00, 0, 0);
        chk("to_set", 32'(timeout_err), 32'(TO_EN));
        step(0, 0, 8'h00, 0, 0);
        chk("to_sticky", 32'({timeout_err, busy, level}), 32'({TO_EN, 1'b1, 3'd1}));
        step(0, 0, 8'h00, 1, 0);
        chk("to_late_ack", 32'({timeout_err, busy, level}), 32'({TO_EN, 1'b0, 3'd0}));
        step(0, 0, 8'h00, 0, 1);
        chk("to_clr", 32'(timeout_err), 32'd0);

        // err_clr coinciding with the timeout edge leaves the flag set.
        step(0, 1, 8'h5A, 0, 0);
        step(0, 0, 8'h00, 0, 0);
        step(0, 0, 8'h00, 0, 0);
        for (int k = 0; k < 15; k++) step(0, 0, 8'h00, 0, 0);
        chk("to_pre2", 32'(timeout_err), 32'd0);
        step(0, 0, 8'h00, 0, 1);
        chk("to_set_wins", 32'(timeout_err), 32'(TO_EN));
        step(0, 0, 8'h00, 1, 1);
        chk("to_clr2", 32'({timeout_err, level, busy}), 32'({1'b0, 3'd0, 1'b0}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
